instr_mem_loader: RTL

- Writer side of the instruction memory. Receives a program as a byte stream (valid/ready) and packs it into N-bit instruction words, MSB byte first.
- Issues single-cycle writes at consecutive word addresses from 0.
- Sits between the host/UART byte source and the write port of the instruction memory, replacing file preload for on-chip program download.

---
 rtl/instr_pkg.sv | 15 +
 rtl/instr_mem_loader_byte_packer.sv | 78 +++++++
 rtl/instr_mem_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared sizing and state type for the instruction-memory download path.
package instr_pkg;

    localparam int N              = 24;
    localparam int ADDR_W         = 10;
    localparam int DEPTH          = 1024;
    localparam int BYTES_PER_WORD = N / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Assembles accepted bytes MSB-first into one instruction word and presents
// the finished word for a single cycle; a short final word is zero-filled.
module instr_mem_loader_byte_packer #(
    parameter int N = instr_pkg::N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         accept,
    input  logic [7:0]   byte_data,
    input  logic         byte_last,
    output logic         word_done,
    output logic         pad_flag,
    output logic         word_valid,
    output logic [N-1:0] word
);
    import instr_pkg::*;

    localparam int B     = N / 8;
    localparam int IDX_W = (B > 1) ? $clog2(B) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     asm_q, asm_d;
    logic [N-1:0]     word_q, word_d;
    logic             valid_q, valid_d;

    // The first byte of a word wipes the assembly register, so any byte slot
    // not reached before byte_last reads back as zero.
    always_comb begin
        idx_d     = idx_q;
        asm_d     = asm_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        word_done = 1'b0;
        pad_flag  = 1'b0;
        if (clear) begin
            idx_d = '0;
            asm_d = '0;
        end else if (accept) begin
            if (idx_q == '0) begin
                asm_d = '0;
            end
            for (int i = 0; i < B; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    asm_d[(B-1-i)*8 +: 8] = byte_data;
                end
            end
            if (idx_q == LAST_IDX || byte_last) begin
                word_done = 1'b1;
                pad_flag  = (idx_q != LAST_IDX);
                valid_d   = 1'b1;
                word_d    = asm_d;
                idx_d     = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program download into the instruction memory write port:
// packs bytes into words and writes them at consecutive addresses from 0.
module instr_mem_loader #(
    parameter int N      = instr_pkg::N,
    parameter int ADDR_W = instr_pkg::ADDR_W,
    parameter int DEPTH  = instr_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              busy,
    output logic              done,
    output logic              partial,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);
    import instr_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              partial_q, partial_d;
    logic              overflow_q, overflow_d;
    logic              full_q, full_d;

    logic              accept;
    logic              packer_clear;
    logic              word_done;
    logic              pad_flag;
    logic              word_valid;
    logic [N-1:0]      word;

    assign accept       = byte_ready && byte_valid;
    assign packer_clear = start && (state_q != LOAD);

    instr_mem_loader_byte_packer #(
        .N (N)
    ) u_byte_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (packer_clear),
        .accept     (accept),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .word_done  (word_done),
        .pad_flag   (pad_flag),
        .word_valid (word_valid),
        .word       (word)
    );

    // The address and count advance on the edge that completes a word, so
    // DONE is already visible in the cycle the final write is on the bus.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        count_d    = count_q;
        partial_d  = partial_q;
        overflow_d = overflow_q;
        full_d     = full_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    count_d    = '0;
                    partial_d  = 1'b0;
                    overflow_d = 1'b0;
                    full_d     = 1'b0;
                end else if (full_q && byte_valid) begin
                    overflow_d = 1'b1;
                end
            end
            LOAD: begin
                if (word_done) begin
                    wr_addr_d = addr_q;
                    count_d   = count_q + 1'b1;
                    partial_d = pad_flag;
                    if (byte_last || addr_q == LAST_ADDR) begin
                        state_d = DONE;
                        full_d  = !byte_last;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            count_q    <= '0;
            partial_q  <= 1'b0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            count_q    <= count_d;
            partial_q  <= partial_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
        end
    end

    assign byte_ready = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign wr_en      = word_valid;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = word;
    assign partial    = partial_q;
    assign overflow   = overflow_q;
    assign word_count = count_q;

endmodule
